sb_serializer: RTL

SB_SERIALIZER -- requirements
Module: sb_serializer

---
 rtl/sb_ser_pkg.sv | 12 +
 rtl/sb_ser_hold_buf.sv | 35 +++
 rtl/sb_serializer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sb_ser_pkg.sv
// Shared types and constants for the sideband serializer.
package sb_ser_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } sb_state_e;

  localparam logic        SB_IDLE_LEVEL   = 1'b1;
  localparam int unsigned SB_SYMBOL_WIDTH = 10;

endpackage

// File: rtl/sb_ser_hold_buf.sv
// One-entry hold buffer that parks the next symbol while the current one shifts out.
module sb_ser_hold_buf
  import sb_ser_pkg::*;
#(
  parameter int unsigned WIDTH = SB_SYMBOL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // A write in the same cycle as a read refills the entry, so full stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (write) begin
      r_data <= data;
      r_full <= 1'b1;
    end else if (read) begin
      r_full <= 1'b0;
    end
  end

  assign rdata = r_data;
  assign full  = r_full;

endmodule

// File: rtl/sb_serializer.sv
// Sideband symbol serializer, LSB first, with back-to-back chaining through a hold buffer.
// Optional start-bit check enabled by defining SB_SER_STARTCHK_EN.
module sb_serializer
  import sb_ser_pkg::*;
#(
  parameter int unsigned WIDTH = SB_SYMBOL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out_bit,
  output logic             busy,
  output logic             frame_done,
  output logic             start_err
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  sb_state_e        r_state, w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_out;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_hold_full, w_hold_wr, w_hold_rd;
  logic             w_accept, w_bad, w_take, w_last;
  logic             w_load_hold, w_load_in;

  assign w_accept = data_valid & data_ready;
  assign w_take   = w_accept & ~w_bad;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LastCnt);

`ifdef SB_SER_STARTCHK_EN
  logic r_start_err;

  assign w_bad = data_in[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_start_err <= 1'b0;
    else     r_start_err <= w_accept & w_bad;
  end

  assign start_err = r_start_err;
`else
  assign w_bad     = 1'b0;
  assign start_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_hold  = 1'b0;
    w_load_in    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_next = SHIFT;
          w_load_in    = 1'b1;
        end
      end
      SHIFT: begin
        // Held word wins over a fresh one so symbols leave in arrival order.
        if (r_cnt == LastCnt) begin
          if (w_hold_full)  w_load_hold  = 1'b1;
          else if (w_take)  w_load_in    = 1'b1;
          else              w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_hold_wr = w_take & (r_state == SHIFT) & ~w_load_in;
  assign w_hold_rd = w_load_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= SB_IDLE_LEVEL;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_load_hold) begin
      r_shift <= w_hold_data;
      r_out   <= w_hold_data[0];
      r_cnt   <= '0;
    end else if (w_load_in) begin
      r_shift <= data_in;
      r_out   <= data_in[0];
      r_cnt   <= '0;
    end else if (r_state == SHIFT && !w_last) begin
      r_shift <= r_shift >> 1;
      r_out   <= r_shift[1];
      r_cnt   <= r_cnt + CntW'(1);
    end else begin
      r_out <= SB_IDLE_LEVEL;
      r_cnt <= '0;
    end
  end

  always_comb begin
    out_bit    = r_out;
    busy       = (r_state == SHIFT);
    frame_done = w_last;
    data_ready = ~w_hold_full;
  end

  sb_ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk  (clk),
    .rst  (rst),
    .write(w_hold_wr),
    .read (w_hold_rd),
    .data (data_in),
    .rdata(w_hold_data),
    .full (w_hold_full)
  );

endmodule
